param_updown_counter: RTL and testbench

Parametrised successor to the team's 8-bit free-running counter. It adds configurable width and modulo limit, up/down direction, synchronous parallel load, a clock prescaler, and wrap or saturate mode. It also provides a terminal-count pulse and a sticky overflow flag. It serves as the general-purpose event/timer counter in datapath and timing blocks.

---
 rtl/counter_pkg.sv | 14 +
 rtl/prescaler_tick.sv | 30 +++
 rtl/param_updown_counter.sv | 84 ++++++++
 tb/tb_param_updown_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter family.
package counter_pkg;

   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } cnt_dir_e;

   // Prescaler phase width; a divide-by-1 prescaler still needs one bit.
   function automatic int unsigned presc_width(input int unsigned prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that completes a period.
module prescaler_tick
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int unsigned    PW   = presc_width(PRESCALE);
   localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;

   // restart wins over a tick so a clear/load never coincides with a step
   assign tick = en && !restart && (phase == LAST);

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST) ? '0 : phase + PW'(1);
      end
   end

endmodule

// File: rtl/param_updown_counter.sv
// General-purpose up/down event counter with modulo limit, prescaler,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

   logic             step;
   logic             restart;
   logic             boundary;
   cnt_dir_e         dir;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_nxt;

   assign restart = clear | load;
   assign dir     = cnt_dir_e'(up);

   prescaler_tick #(
      .PRESCALE (PRESCALE)
   ) u_presc (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .restart (restart),
      .tick    (step)
   );

   assign boundary = step && ((dir == CNT_UP) ? (count == MAXV) : (count == '0));

   // Boundary values are selected explicitly so a full-range MAX_VAL never
   // relies on the adder rolling over.
   always_comb begin
      load_clamped = (load_val > MAXV) ? MAXV : load_val;
      count_nxt    = count;
      if (clear) begin
         count_nxt = '0;
      end else if (load) begin
         count_nxt = load_clamped;
      end else if (step) begin
         case (dir)
            CNT_UP: begin
               if (count == MAXV) count_nxt = (SATURATE != 0) ? MAXV : '0;
               else               count_nxt = count + WIDTH'(1);
            end
            default: begin
               if (count == '0) count_nxt = (SATURATE != 0) ? '0 : MAXV;
               else             count_nxt = count - WIDTH'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= boundary;
         // a new boundary crossing beats a simultaneous clear request
         ovf   <= boundary | (ovf & ~ovf_clr);
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Four differently parametrised counters share one stimulus stream and are
// checked against an arithmetic reference model.
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, clear, load, ovf_clr;
   logic [7:0] load_val;

   logic [7:0] c0;
   logic [3:0] c1, c2, c3;
   logic       tc0, tc1, tc2, tc3, ov0, ov1, ov2, ov3;

   logic [7:0] ocnt [4];
   logic       otc  [4];
   logic       oovf [4];

   int pw   [4] = '{8, 4, 4, 4};
   int pmax [4] = '{255, 9, 9, 9};
   int ppre [4] = '{1, 1, 1, 3};
   int psat [4] = '{0, 0, 1, 0};

   int mc [4];
   int mp [4];
   int mt [4];
   int mo [4];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   param_updown_counter u_d0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .ovf_clr(ovf_clr), .count(c0), .tc(tc0), .ovf(ov0));

   param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c1), .tc(tc1), .ovf(ov1));

   param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1)) u_d2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c2), .tc(tc2), .ovf(ov2));

   param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(0)) u_d3 (
      .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(c3), .tc(tc3), .ovf(ov3));

   assign ocnt[0] = c0;
   assign ocnt[1] = {4'b0, c1};
   assign ocnt[2] = {4'b0, c2};
   assign ocnt[3] = {4'b0, c3};
   assign otc[0]  = tc0;
   assign otc[1]  = tc1;
   assign otc[2]  = tc2;
   assign otc[3]  = tc3;
   assign oovf[0] = ov0;
   assign oovf[1] = ov1;
   assign oovf[2] = ov2;
   assign oovf[3] = ov3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: per-edge behaviour in plain modular arithmetic.
   task automatic model_step();
      for (int i = 0; i < 4; i++) begin
         int lv;
         int bnd;
         bnd = 0;
         lv  = int'(load_val) % (1 << pw[i]);
         if (rst) begin
            mc[i] = 0; mp[i] = 0; mt[i] = 0; mo[i] = 0;
         end else begin
            if (clear) begin
               mc[i] = 0; mp[i] = 0;
            end else if (load) begin
               mc[i] = (lv > pmax[i]) ? pmax[i] : lv;
               mp[i] = 0;
            end else if (en) begin
               mp[i] = mp[i] + 1;
               if (mp[i] == ppre[i]) begin
                  mp[i] = 0;
                  if (up) begin
                     bnd = (mc[i] == pmax[i]) ? 1 : 0;
                     if (psat[i] != 0) mc[i] = (mc[i] + 1 > pmax[i]) ? pmax[i] : mc[i] + 1;
                     else              mc[i] = (mc[i] + 1) % (pmax[i] + 1);
                  end else begin
                     bnd = (mc[i] == 0) ? 1 : 0;
                     if (psat[i] != 0) mc[i] = (mc[i] == 0) ? 0 : mc[i] - 1;
                     else              mc[i] = (mc[i] + pmax[i]) % (pmax[i] + 1);
                  end
               end
            end
            mt[i] = bnd;
            if (bnd != 0)    mo[i] = 1;
            else if (ovf_clr) mo[i] = 0;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("count%0d", i), 32'(ocnt[i]), 32'(mc[i]));
         chk($sformatf("tc%0d", i),    32'(otc[i]),  32'(mt[i]));
         chk($sformatf("ovf%0d", i),   32'(oovf[i]), 32'(mo[i]));
      end
   endtask

   initial begin
      foreach (mc[i]) begin mc[i] = 0; mp[i] = 0; mt[i] = 0; mo[i] = 0; end
      rst = 1'b1; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0;
      load_val = 8'd0; ovf_clr = 1'b0;

      // reset hold, then count up
      repeat (3) cycle();
      chk("rst_count0", 32'(c0), 32'd0);
      chk("rst_tc0", 32'(tc0), 32'd0);
      chk("rst_ovf0", 32'(ov0), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cycle();
         chk("seq_count0", 32'(c0), 32'(k));
      end

      // wrap up through MAX_VAL=9
      clear = 1'b1; cycle(); clear = 1'b0;
      repeat (10) cycle();
      chk("wrap_count1", 32'(c1), 32'd0);
      chk("wrap_tc1", 32'(tc1), 32'd1);
      chk("wrap_ovf1", 32'(ov1), 32'd1);

      // saturate down from 2
      load = 1'b1; load_val = 8'd2; cycle(); load = 1'b0;
      up = 1'b0;
      repeat (4) cycle();
      chk("sat_count2", 32'(c2), 32'd0);
      chk("sat_tc2", 32'(tc2), 32'd1);
      chk("sat_ovf2", 32'(ov2), 32'd1);
      en = 1'b0; ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
      chk("satclr_ovf2", 32'(ov2), 32'd0);

      // prescale by 3 with an enable gap
      up = 1'b1; clear = 1'b1; cycle(); clear = 1'b0;
      en = 1'b1; repeat (4) cycle();
      en = 1'b0; repeat (2) cycle();
      chk("presc_freeze3", 32'(c3), 32'd1);
      en = 1'b1; repeat (5) cycle();
      chk("presc_count3", 32'(c3), 32'd3);

      // priority and load clamp
      clear = 1'b1; load = 1'b1; load_val = 8'd15; cycle();
      chk("prio_clear1", 32'(c1), 32'd0);
      clear = 1'b0; cycle();
      chk("clamp_count1", 32'(c1), 32'd9);
      chk("noclamp_count0", 32'(c0), 32'd15);
      rst = 1'b1; cycle();
      chk("prio_rst0", 32'(c0), 32'd0);
      chk("prio_rst1", 32'(c1), 32'd0);

      // ovf set beats simultaneous ovf_clr
      rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b0;
      cycle();
      chk("race_set2", 32'(ov2), 32'd1);
      ovf_clr = 1'b1; cycle();
      chk("race_hold2", 32'(ov2), 32'd1);
      en = 1'b0; cycle(); ovf_clr = 1'b0;
      chk("race_clr2", 32'(ov2), 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 63) == 0);
         clear    = ($urandom_range(0, 15) == 0);
         load     = ($urandom_range(0, 15) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = ($urandom_range(0, 3) != 0);
         ovf_clr  = ($urandom_range(0, 7) == 0);
         load_val = 8'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
